// File: rtl/sq_buffer_pkg.sv
// sq_buffer_pkg: shared constants and helpers for the stack/queue buffer.
package sq_buffer_pkg;

   localparam logic MODE_LIFO = 1'b0;
   localparam logic MODE_FIFO = 1'b1;

   function automatic int count_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Explicit compare keeps wrapping correct for non-power-of-two depths.
   function automatic int wrap_inc(input int ptr, input int depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/sq_buffer_ram.sv
// sq_buffer_ram: DEPTH x DATA_WIDTH storage, one synchronous write port, one read port.
module sq_buffer_ram #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int AW         = $clog2(DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [AW-1:0]         waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]         raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stack_queue_buffer.sv
// stack_queue_buffer: LIFO/FIFO buffer with occupancy, threshold flags and sticky errors.
module stack_queue_buffer
   import sq_buffer_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int AF_LEVEL   = DEPTH - 2,
   parameter int AE_LEVEL   = 2
) (
   input  logic                          Clk,
   input  logic                          Rst_n,
   input  logic                          MODE,
   input  logic                          PUSH,
   input  logic                          POP,
   input  logic [DATA_WIDTH-1:0]         dataIn,
   input  logic                          CLR_ERR,
   output logic [DATA_WIDTH-1:0]         dataOut,
   output logic                          VALID,
   output logic [count_width(DEPTH)-1:0] COUNT,
   output logic                          EMPTY,
   output logic                          FULL,
   output logic                          ALMOST_EMPTY,
   output logic                          ALMOST_FULL,
   output logic                          OVERFLOW,
   output logic                          UNDERFLOW
);

   localparam int CW = count_width(DEPTH);
   localparam int PW = $clog2(DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

   logic [CW-1:0]         count_q, count_d;
   logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
   logic                  mode_q, mode_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  valid_q, empty_q, full_q, ae_q, af_q, ovf_q, ovf_d, udf_q, udf_d;
   logic                  is_empty, is_full, fifo, do_pop, do_push;
   logic [PW-1:0]         top, waddr, raddr;
   logic [DATA_WIDTH-1:0] rdata;

   // A push alongside an accepted pop never overflows: the slot is reused.
   always_comb begin
      is_empty = count_q == '0;
      is_full  = count_q == DEPTH_C;
      fifo     = mode_q == MODE_FIFO;
      do_pop   = POP & ~is_empty;
      do_push  = PUSH & (~is_full | do_pop);
      top      = PW'(count_q - 1'b1);
      waddr    = fifo ? tail_q : (do_pop ? top : PW'(count_q));
      raddr    = fifo ? head_q : top;
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
      head_d   = (fifo && do_pop) ? PW'(wrap_inc(int'(head_q), DEPTH)) : head_q;
      tail_d   = (fifo && do_push) ? PW'(wrap_inc(int'(tail_q), DEPTH)) : tail_q;
      mode_d   = (is_empty && !PUSH) ? MODE : mode_q;
      dout_d   = do_pop ? rdata : dout_q;
      ovf_d    = (PUSH & is_full & ~do_pop) | (ovf_q & ~CLR_ERR);
      udf_d    = (POP & is_empty) | (udf_q & ~CLR_ERR);
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         count_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         mode_q  <= MODE_LIFO;
         dout_q  <= '0;
         valid_q <= 1'b0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         ae_q    <= 1'b1;
         af_q    <= AF_LEVEL == 0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         mode_q  <= mode_d;
         dout_q  <= dout_d;
         valid_q <= do_pop;
         empty_q <= count_d == '0;
         full_q  <= count_d == DEPTH_C;
         ae_q    <= count_d <= AE_C;
         af_q    <= count_d >= AF_C;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   sq_buffer_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .AW(PW)) u_ram (
      .clk_i   (Clk),
      .we_i    (do_push),
      .waddr_i (waddr),
      .wdata_i (dataIn),
      .raddr_i (raddr),
      .rdata_o (rdata)
   );

   assign dataOut      = dout_q;
   assign VALID        = valid_q;
   assign COUNT        = count_q;
   assign EMPTY        = empty_q;
   assign FULL         = full_q;
   assign ALMOST_EMPTY = ae_q;
   assign ALMOST_FULL  = af_q;
   assign OVERFLOW     = ovf_q;
   assign UNDERFLOW    = udf_q;

endmodule

// File: doc/stack_queue_buffer.md
# stack_queue_buffer

Parametrised single-clock storage buffer that operates as a LIFO stack or a FIFO queue, selected by a mode input. It extends the team's fixed LIFO memory with:
- generic width and depth;
- programmable almost-full/almost-empty thresholds and an occupancy count;
- defined simultaneous push/pop behaviour;
- sticky overflow/underflow error flags.

It sits between a producer and consumer in the datapath and serves as the shared buffering primitive for both stack and queue use.

## Interface
- DATA_WIDTH, 8, word width in bits (≥1)
- DEPTH, 16, number of entries (≥2, need not be a power of two)
- AF_LEVEL, DEPTH-2, ALMOST_FULL asserted when COUNT ≥ AF_LEVEL
- AE_LEVEL, 2, ALMOST_EMPTY asserted when COUNT ≤ AE_LEVEL
- Clk  in  1  clock, all state updates on the rising edge
- Rst_n  in  1  reset, asynchronous, active-low
- MODE  in  1  0 = LIFO, 1 = FIFO; latched only while empty
- PUSH  in  1  write request for this cycle
- POP  in  1  read request for this cycle
- dataIn  in  DATA_WIDTH  word to push
- CLR_ERR  in  1  synchronous clear of OVERFLOW/UNDERFLOW
- dataOut  out  DATA_WIDTH  registered popped word
- VALID  out  1  one-cycle pulse: dataOut was updated by an accepted pop
- COUNT  out  $clog2(DEPTH+1)  current occupancy
- EMPTY, FULL  out  1  COUNT==0 / COUNT==DEPTH
- ALMOST_EMPTY, ALMOST_FULL  out  1  threshold flags
- OVERFLOW, UNDERFLOW  out  1  sticky error flags

## Operation
- Reset (async assert, sync-safe deassert) values:
  - dataOut=0, VALID=0, COUNT=0, EMPTY=1, FULL=0;
  - ALMOST_EMPTY=1, ALMOST_FULL=(AF_LEVEL==0);
  - OVERFLOW=0, UNDERFLOW=0;
  - mode register=LIFO; all pointers=0.
- Reset asserted mid-operation discards all contents immediately. Memory array contents are not reset.
- Mode register:
  - Loads MODE on every cycle where COUNT==0 and PUSH=0.
  - Otherwise it holds. A MODE change while non-empty is ignored until the buffer drains.
- LIFO storage: top-of-stack index = COUNT-1. Push writes entry[COUNT]; pop reads entry[COUNT-1].
- FIFO storage: tail pointer (write) and head pointer (read), each wrapping from DEPTH-1 to 0 by explicit compare, not by bit truncation.
- Request resolution per cycle:
  - PUSH only, not full: write, COUNT+1.
  - PUSH only, full: write dropped, OVERFLOW←1, state unchanged.
  - POP only, not empty: read to dataOut, VALID=1, COUNT-1.
  - POP only, empty: UNDERFLOW←1, dataOut holds, VALID=0.
  - PUSH+POP, empty (both modes): push accepted, pop rejected, UNDERFLOW←1. There is no bypass.
  - PUSH+POP, LIFO, non-empty (including full): dataOut←old top, top entry replaced by dataIn, COUNT unchanged.
  - PUSH+POP, FIFO, non-empty (including full): dataOut←head, dataIn written at tail, both pointers advance, COUNT unchanged. No OVERFLOW.
- Error flags:
  - Once set, they hold until CLR_ERR=1.
  - If CLR_ERR and a new error occur in the same cycle, the new error wins and the flag stays 1.
- Status flags are registered and derived from the next-state COUNT, so they are valid in the same cycle as COUNT.

## Timing
- Pop latency: one cycle. A pop accepted at edge N makes dataOut/VALID valid after edge N, and they are sampled at edge N+1.
- dataOut holds its last popped value indefinitely. VALID is high for exactly one cycle per accepted pop.
- A pushed word is poppable on the next cycle.
- Back-to-back pushes or pops every cycle are supported at full rate.
- COUNT and all flags update on the same edge as the accepted operation. No combinational path exists from inputs to outputs.

## Structure
- Package sq_buffer_pkg holds:
  - MODE_LIFO/MODE_FIFO constants;
  - the count-width function (clog2 of DEPTH+1);
  - the pointer-wrap helper.
- One sub-module, sq_buffer_ram: a DEPTH×DATA_WIDTH single-clock array with one synchronous write port and one read port.
- Control, pointers, counters and flags live in stack_queue_buffer.

## Test plan
All scenarios use DATA_WIDTH=8, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2.
- LIFO fill/drain: push 0x00..0x0F → FULL=1 and COUNT=16 after the 16th push; 16 pops → dataOut 0x0F..0x00, EMPTY=1, no error flags.
- FIFO wrap: MODE=1, push 0x00..0x09, pop 6, push 0x0A..0x13 (tail wraps) → remaining pops yield 0x06..0x13 in order, COUNT returns to 0.
- Errors: push 17 words → OVERFLOW=1, and the 17th word is absent on drain; pop when empty → UNDERFLOW=1; assert CLR_ERR for one cycle → both flags 0.
- Simultaneous operations:
  - LIFO holding 0xAA,0xBB, PUSH+POP with dataIn=0xCC → dataOut=0xBB, COUNT=2, next pop=0xCC.
  - FIFO full, PUSH+POP → no OVERFLOW, COUNT=16.
- Thresholds and mode latch:
  - ALMOST_FULL rises at COUNT=14; ALMOST_EMPTY falls at COUNT=3.
  - Toggle MODE with COUNT=5 → order unchanged until empty.
- Async reset mid-stream: drop Rst_n between edges with COUNT=7 → outputs go to reset values immediately (before the next edge), and after release the first pop reports UNDERFLOW.
